branch_sequencer: RTL and testbench

// - Issuing side of the branch-decision interface. Accepts decoded branch instructions and snapshots the ALU flags.
// - Drives zero/MSB/ShortBr/ShortBrType to the branch decider and consumes its ShortBr_out verdict.
// - Computes the target and redirects fetch through a valid/ready handshake; writes the link register on branch-and-link.

---
 rtl/miniRISC_pkg.sv | 17 +
 rtl/branch_target_adder.sv | 21 ++
 rtl/branch_sequencer.sv | 131 +++++++++++++
 tb/tb_branch_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/miniRISC_pkg.sv
// Shared encodings for the miniRISC branch path.
package miniRISC_pkg;

  // Conditional (short) branch condition encodings
  localparam logic [1:0] SHORT_BR_ZERO    = 2'b00;
  localparam logic [1:0] SHORT_BR_NOTZERO = 2'b01;
  localparam logic [1:0] SHORT_BR_NEG     = 2'b10;
  localparam logic [1:0] SHORT_BR_POS     = 2'b11;

  // Branch sequencer states
  typedef enum logic [1:0] {
    BSEQ_IDLE     = 2'b00,
    BSEQ_EVAL     = 2'b01,
    BSEQ_REDIRECT = 2'b10
  } bseq_state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target and return-address arithmetic, both modulo 2^ADDR_W.
module branch_target_adder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMM_W  = 16
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [ADDR_W-1:0] target_o,
  output logic [ADDR_W-1:0] pc_plus4_o
);

  logic [ADDR_W-1:0] imm_sext;

  // Sign-extend the byte offset and form both sums
  always_comb begin
    imm_sext   = {{(ADDR_W - IMM_W){imm_i[IMM_W-1]}}, imm_i};
    target_o   = pc_i + imm_sext;
    pc_plus4_o = pc_i + ADDR_W'(4);
  end

endmodule

// File: rtl/branch_sequencer.sv
// Issues decoded branches to the branch decider, redirects fetch on taken
// branches and writes the link register on branch-and-link.
module branch_sequencer
  import miniRISC_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic              dec_is_short,
  input  logic [1:0]        dec_short_type,
  input  logic              dec_is_link,
  input  logic [ADDR_W-1:0] dec_pc,
  input  logic [IMM_W-1:0]  dec_imm,
  input  logic              alu_flag_we,
  input  logic              alu_zero,
  input  logic              alu_msb,
  output logic              bd_short_br,
  output logic [1:0]        bd_short_type,
  output logic              bd_zero,
  output logic              bd_msb,
  input  logic              bd_taken,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [ADDR_W-1:0] redir_pc,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic [CNT_W-1:0]  taken_cnt
);

  bseq_state_e       state_q, state_d;
  logic [1:0]        flag_q;      // {zero, msb}
  logic [1:0]        snap_flags;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_plus4;
  logic              accept;
  logic              do_link;
  logic              eval_taken;
  logic              handshake;

  branch_target_adder #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_adder (
    .pc_i       (dec_pc),
    .imm_i      (dec_imm),
    .target_o   (target),
    .pc_plus4_o (pc_plus4)
  );

  // Handshake qualifiers; a same-cycle flag write is forwarded into the snapshot
  always_comb begin
    accept     = dec_valid && (state_q == BSEQ_IDLE);
    do_link    = dec_is_link && !dec_is_short;
    snap_flags = alu_flag_we ? {alu_zero, alu_msb} : flag_q;
    eval_taken = bd_short_br ? bd_taken : 1'b1;
    handshake  = redir_valid && redir_ready;
  end

  // Flush marks the accepted redirect in the handshake cycle itself
  assign flush = handshake;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BSEQ_IDLE:     if (dec_valid) state_d = BSEQ_EVAL;
      BSEQ_EVAL:     state_d = eval_taken ? BSEQ_REDIRECT : BSEQ_IDLE;
      BSEQ_REDIRECT: if (redir_ready) state_d = BSEQ_IDLE;
      default:       state_d = BSEQ_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BSEQ_IDLE;
    else        state_q <= state_d;
  end

  // ALU flag register, updated whenever the ALU strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           flag_q <= 2'b00;
    else if (alu_flag_we) flag_q <= {alu_zero, alu_msb};
  end

  // Target snapshot taken at accept, held until the redirect is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      target_q <= '0;
    else if (accept) target_q <= target;
  end

  // Registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_ready     <= 1'b1;
      bd_short_br   <= 1'b0;
      bd_short_type <= 2'b00;
      bd_zero       <= 1'b0;
      bd_msb        <= 1'b0;
      link_we       <= 1'b0;
      link_data     <= '0;
      redir_valid   <= 1'b0;
      redir_pc      <= '0;
    end else begin
      dec_ready     <= (state_d == BSEQ_IDLE);
      bd_short_br   <= accept && dec_is_short;
      bd_short_type <= accept ? dec_short_type : 2'b00;
      bd_zero       <= accept && snap_flags[1];
      bd_msb        <= accept && snap_flags[0];
      link_we       <= accept && do_link;
      link_data     <= (accept && do_link) ? pc_plus4 : '0;
      redir_valid   <= (state_d == BSEQ_REDIRECT);
      redir_pc      <= (state_d == BSEQ_REDIRECT) ? target_q : '0;
    end
  end

  // Taken-branch counter, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      taken_cnt <= '0;
    else if (handshake && (taken_cnt != {CNT_W{1'b1}}))
      taken_cnt <= taken_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a default-width instance and a
// CNT_W=2 instance share stimulus; each has its own branch-decider model.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_is_short, dec_is_link;
  logic [1:0]  dec_short_type;
  logic [31:0] dec_pc;
  logic [15:0] dec_imm;
  logic        alu_flag_we, alu_zero, alu_msb;
  logic        redir_ready;

  logic        dec_ready, bd_short_br, bd_zero, bd_msb, bd_taken;
  logic [1:0]  bd_short_type;
  logic        redir_valid, flush, link_we;
  logic [31:0] redir_pc, link_data;
  logic [15:0] taken_cnt;

  logic        s_dec_ready, s_bd_short_br, s_bd_zero, s_bd_msb, s_bd_taken;
  logic [1:0]  s_bd_short_type;
  logic        s_redir_valid, s_flush, s_link_we;
  logic [31:0] s_redir_pc, s_link_data;
  logic [1:0]  s_taken_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic decide(input logic [1:0] t, input logic z, input logic m);
    case (t)
      2'b00:   return z;
      2'b01:   return !z;
      2'b10:   return m;
      default: return !m && !z;
    endcase
  endfunction

  assign bd_taken   = decide(bd_short_type, bd_zero, bd_msb);
  assign s_bd_taken = decide(s_bd_short_type, s_bd_zero, s_bd_msb);

  branch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_is_short(dec_is_short), .dec_short_type(dec_short_type),
    .dec_is_link(dec_is_link), .dec_pc(dec_pc), .dec_imm(dec_imm),
    .alu_flag_we(alu_flag_we), .alu_zero(alu_zero), .alu_msb(alu_msb),
    .bd_short_br(bd_short_br), .bd_short_type(bd_short_type),
    .bd_zero(bd_zero), .bd_msb(bd_msb), .bd_taken(bd_taken),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .flush(flush), .link_we(link_we), .link_data(link_data),
    .taken_cnt(taken_cnt)
  );

  branch_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(s_dec_ready),
    .dec_is_short(dec_is_short), .dec_short_type(dec_short_type),
    .dec_is_link(dec_is_link), .dec_pc(dec_pc), .dec_imm(dec_imm),
    .alu_flag_we(alu_flag_we), .alu_zero(alu_zero), .alu_msb(alu_msb),
    .bd_short_br(s_bd_short_br), .bd_short_type(s_bd_short_type),
    .bd_zero(s_bd_zero), .bd_msb(s_bd_msb), .bd_taken(s_bd_taken),
    .redir_valid(s_redir_valid), .redir_ready(redir_ready), .redir_pc(s_redir_pc),
    .flush(s_flush), .link_we(s_link_we), .link_data(s_link_data),
    .taken_cnt(s_taken_cnt)
  );

  typedef struct {
    string       name;
    logic        is_short;
    logic [1:0]  typ;
    logic        is_link;
    logic [31:0] pc;
    logic [15:0] imm;
    logic        z;
    logic        m;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic        exp_link_we;
    logic [31:0] exp_link_data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat3(input int n);
    return (n > 3) ? 32'd3 : 32'(n);
  endfunction

  task automatic apply_vec(input vec_t v);
    alu_flag_we = 1'b1; alu_zero = v.z; alu_msb = v.m;
    step();
    alu_flag_we = 1'b0;
    dec_valid = 1'b1; dec_is_short = v.is_short; dec_short_type = v.typ;
    dec_is_link = v.is_link; dec_pc = v.pc; dec_imm = v.imm;
    step();
    dec_valid = 1'b0;
    chk({v.name, " eval dec_ready"}, 32'(dec_ready), 32'd0);
    chk({v.name, " bd_short_br"}, 32'(bd_short_br), 32'(v.is_short));
    chk({v.name, " bd_short_type"}, 32'(bd_short_type), 32'(v.typ));
    chk({v.name, " bd_zero"}, 32'(bd_zero), 32'(v.z));
    chk({v.name, " bd_msb"}, 32'(bd_msb), 32'(v.m));
    chk({v.name, " link_we"}, 32'(link_we), 32'(v.exp_link_we));
    if (v.exp_link_we) chk({v.name, " link_data"}, link_data, v.exp_link_data);
    step();
    chk({v.name, " redir_valid"}, 32'(redir_valid), 32'(v.exp_taken));
    chk({v.name, " link_we pulse"}, 32'(link_we), 32'd0);
    if (v.exp_taken) begin
      chk({v.name, " redir_pc"}, redir_pc, v.exp_target);
      chk({v.name, " dec_ready in redirect"}, 32'(dec_ready), 32'd0);
      redir_ready = 1'b1;
      #1;
      chk({v.name, " flush"}, 32'(flush), 32'd1);
      step();
      redir_ready = 1'b0;
      exp_cnt++;
      chk({v.name, " flush pulse"}, 32'(flush), 32'd0);
      chk({v.name, " redir_valid drop"}, 32'(redir_valid), 32'd0);
    end else begin
      chk({v.name, " dec_ready T+2"}, 32'(dec_ready), 32'd1);
    end
    chk({v.name, " taken_cnt"}, 32'(taken_cnt), 32'(exp_cnt));
    chk({v.name, " sat taken_cnt"}, 32'(s_taken_cnt), sat3(exp_cnt));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dec_ready"}, 32'(dec_ready), 32'd1);
    chk({tag, " bd_*"}, {26'd0, bd_short_br, bd_short_type, bd_zero, bd_msb, 1'b0}, 32'd0);
    chk({tag, " redir_valid"}, 32'(redir_valid), 32'd0);
    chk({tag, " redir_pc"}, redir_pc, 32'd0);
    chk({tag, " flush"}, 32'(flush), 32'd0);
    chk({tag, " link"}, {31'd0, link_we} | link_data, 32'd0);
    chk({tag, " taken_cnt"}, 32'(taken_cnt), 32'd0);
    chk({tag, " sat taken_cnt"}, 32'(s_taken_cnt), 32'd0);
    chk({tag, " sat redir_valid"}, 32'(s_redir_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"bz taken",      1'b1, 2'b00, 1'b0, 32'h0000_0100, 16'h0010, 1'b1, 1'b0, 1'b1, 32'h0000_0110, 1'b0, 32'h0};
    vecs[1] = '{"bnz not taken", 1'b1, 2'b01, 1'b0, 32'h0000_0200, 16'h0020, 1'b1, 1'b0, 1'b0, 32'h0000_0220, 1'b0, 32'h0};
    vecs[2] = '{"bneg taken",    1'b1, 2'b10, 1'b0, 32'h0000_1000, 16'hFFF0, 1'b0, 1'b1, 1'b1, 32'h0000_0FF0, 1'b0, 32'h0};
    vecs[3] = '{"bpos not taken",1'b1, 2'b11, 1'b0, 32'h0000_0300, 16'h0004, 1'b0, 1'b1, 1'b0, 32'h0000_0304, 1'b0, 32'h0};
    vecs[4] = '{"bpos taken",    1'b1, 2'b11, 1'b0, 32'h0000_0400, 16'h8000, 1'b0, 1'b0, 1'b1, 32'hFFFF_8400, 1'b0, 32'h0};
    vecs[5] = '{"bl wrap",       1'b0, 2'b00, 1'b1, 32'hFFFF_FFFC, 16'h0008, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
    vecs[6] = '{"b uncond",      1'b0, 2'b00, 1'b0, 32'h0000_0050, 16'h7FFE, 1'b0, 1'b0, 1'b1, 32'h0000_804E, 1'b0, 32'h0};
    vecs[7] = '{"short+link",    1'b1, 2'b00, 1'b1, 32'h0000_0060, 16'h0010, 1'b0, 1'b0, 1'b0, 32'h0000_0070, 1'b0, 32'h0};

    rst_n = 1'b0;
    dec_valid = 1'b0; dec_is_short = 1'b0; dec_is_link = 1'b0;
    dec_short_type = 2'b00; dec_pc = '0; dec_imm = '0;
    alu_flag_we = 1'b0; alu_zero = 1'b0; alu_msb = 1'b0;
    redir_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // redir_ready with no pending request does nothing
    redir_ready = 1'b1;
    #1;
    chk("stray ready flush", 32'(flush), 32'd0);
    step();
    redir_ready = 1'b0;
    chk("stray ready taken_cnt", 32'(taken_cnt), 32'd0);
    chk("stray ready dec_ready", 32'(dec_ready), 32'd1);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Forwarding: register holds zero=0, accept-cycle write supplies zero=1
    alu_flag_we = 1'b1; alu_zero = 1'b0; alu_msb = 1'b0;
    step();
    alu_zero = 1'b1;
    dec_valid = 1'b1; dec_is_short = 1'b1; dec_short_type = 2'b00;
    dec_is_link = 1'b0; dec_pc = 32'h0000_0800; dec_imm = 16'h0100;
    step();
    // Late flag write during EVAL must not alter the snapshot
    alu_zero = 1'b0;
    dec_pc = 32'h0000_0900;
    chk("fwd bd_zero", 32'(bd_zero), 32'd1);
    step();
    alu_flag_we = 1'b0;
    chk("fwd taken redir_valid", 32'(redir_valid), 32'd1);
    chk("fwd redir_pc", redir_pc, 32'h0000_0900);
    // Backpressure: request held stable, decode ignored while busy
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp redir_valid", 32'(redir_valid), 32'd1);
      chk("bp redir_pc stable", redir_pc, 32'h0000_0900);
      chk("bp dec_ready", 32'(dec_ready), 32'd0);
      chk("bp flush", 32'(flush), 32'd0);
    end
    chk("bp taken_cnt held", 32'(taken_cnt), 32'(exp_cnt));
    // Asynchronous reset mid-REDIRECT
    #2;
    rst_n = 1'b0;
    dec_valid = 1'b0;
    #1;
    chk_reset_outputs("mid-redirect reset");
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Counter restarts after reset
    apply_vec(vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
